cpu_test_ctrl: RTL



---
 rtl/cpu_test_pkg.sv | 21 ++
 rtl/cpu_hang_detector.sv | 50 +++++
 rtl/cpu_test_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cpu_test_pkg.sv
// cpu_test_pkg: shared encodings for the cpu_test_ctrl harness controller.
//   status_e    - FSM state, also driven out directly as the 3-bit status word
//   STATUS_W    - width of the status word
//   TOHOST_PASS - tohost value that signals a passing test
package cpu_test_pkg;

  localparam int STATUS_W = 3;

  // HOLD (core held in reset) reports as IDLE, so one encoding serves both.
  typedef enum logic [STATUS_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_HANG    = 3'd5
  } status_e;

  localparam int unsigned TOHOST_PASS = 1;

endpackage

// File: rtl/cpu_hang_detector.sv
// cpu_hang_detector: flags a core spinning on one PC (jump-to-self).
//   clk, rst        - clock, async active-high reset
//   en_i            - tracking enabled (controller in RUN)
//   retire_valid_i  - one instruction retired this cycle
//   retire_pc_i     - PC of that instruction
//   hang_hit_o      - this retirement is the HANG_LIMIT-th in a row at one PC
module cpu_hang_detector #(
  parameter int XLEN       = 32,
  parameter int HANG_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            retire_valid_i,
  input  logic [XLEN-1:0] retire_pc_i,
  output logic            hang_hit_o
);

  localparam int HC_W = (HANG_LIMIT < 2) ? 2 : $clog2(HANG_LIMIT + 1);

  logic [XLEN-1:0] last_pc_q;
  logic            valid_q;
  logic [HC_W-1:0] cnt_q, cnt_d;
  logic            same_pc;

  // last_pc is meaningless until the first retirement, so the first one
  // after reset always starts a fresh run of length 1.
  assign same_pc = valid_q && (retire_pc_i == last_pc_q);

  always_comb begin
    cnt_d = HC_W'(1);
    if (same_pc) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + HC_W'(1);
  end

  assign hang_hit_o = (HANG_LIMIT != 0) && en_i && retire_valid_i &&
                      (cnt_d == HC_W'(HANG_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pc_q <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else if (en_i && retire_valid_i) begin
      last_pc_q <= retire_pc_i;
      valid_q   <= 1'b1;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_test_ctrl.sv
// cpu_test_ctrl: test-harness controller around cpu_top. Sequences core
// reset, counts cycles/retirements, and turns tohost writes, timeout or a
// jump-to-self hang into a sticky end-of-test status.
//   clk, rst             - clock, async active-high reset
//   core_rst             - registered reset to the core
//   dmem_we/addr/wdata   - data-memory write snoop
//   retire_valid/pc      - retirement snoop
//   done, pass, status   - end-of-test result (status = IDLE..HANG)
//   fail_code            - tohost value >> 1 on a failing write
//   cycle_count          - RUN cycles elapsed
//   instret_count        - instructions retired in RUN
module cpu_test_ctrl
  import cpu_test_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              RST_CYCLES     = 2,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = 'h0000_1000,
  parameter int              TIMEOUT_CYCLES = 550,
  parameter int              HANG_LIMIT     = 8,
  parameter int              CNT_W          = 32
) (
  input  logic                clk,
  input  logic                rst,
  output logic                core_rst,
  input  logic                dmem_we,
  input  logic [XLEN-1:0]     dmem_addr,
  input  logic [XLEN-1:0]     dmem_wdata,
  input  logic                retire_valid,
  input  logic [XLEN-1:0]     retire_pc,
  output logic                done,
  output logic                pass,
  output logic [STATUS_W-1:0] status,
  output logic [XLEN-2:0]     fail_code,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    instret_count
);

  localparam int HOLD_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);

  status_e          state_q;
  logic             core_rst_q, done_q, pass_q;
  logic [XLEN-2:0]  fail_code_q;
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic [HOLD_W-1:0] hold_q;

  logic tohost_hit, timeout_hit, hang_hit, in_run;

  assign in_run = (state_q == ST_RUN);

  // bit0 = 0 is the syscall convention, not an end-of-test report.
  assign tohost_hit = dmem_we && (dmem_addr == TOHOST_ADDR) && dmem_wdata[0];

  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1));

  cpu_hang_detector #(
    .XLEN       (XLEN),
    .HANG_LIMIT (HANG_LIMIT)
  ) u_hang (
    .clk            (clk),
    .rst            (rst),
    .en_i           (in_run),
    .retire_valid_i (retire_valid),
    .retire_pc_i    (retire_pc),
    .hang_hit_o     (hang_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_code_q <= '0;
      cycle_q     <= '0;
      instret_q   <= '0;
      hold_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hold_q == HOLD_W'(RST_CYCLES - 1)) begin
            state_q    <= ST_RUN;
            core_rst_q <= 1'b0;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          // The terminating cycle is still a RUN cycle and still counts.
          cycle_q <= cycle_q + CNT_W'(1);
          if (retire_valid) instret_q <= instret_q + CNT_W'(1);
          if (tohost_hit) begin
            done_q <= 1'b1;
            if (dmem_wdata == XLEN'(TOHOST_PASS)) begin
              state_q <= ST_PASS;
              pass_q  <= 1'b1;
            end else begin
              state_q     <= ST_FAIL;
              fail_code_q <= dmem_wdata[XLEN-1:1];
            end
          end else if (hang_hit) begin
            state_q <= ST_HANG;
            done_q  <= 1'b1;
          end else if (timeout_hit) begin
            state_q <= ST_TIMEOUT;
            done_q  <= 1'b1;
          end
        end
        default: ;  // terminal states absorb until rst
      endcase
    end
  end

  assign core_rst      = core_rst_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign status        = state_q;
  assign fail_code     = fail_code_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule
